// File: rtl/dma_copia.sv
// dma_copia: block copy engine for a single-port word memory.
// Copies quantidade words from origem to destino with memmove semantics,
// one read (LE) and one write (ESCREVE) per word.
module dma_copia #(
    parameter int unsigned bits = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            inicio,
    input  logic [bits-1:0] origem,
    input  logic [bits-1:0] destino,
    input  logic [bits-1:0] quantidade,
    output logic            ocupado,
    output logic            pronto,
    output logic            mem_write,
    output logic [bits-1:0] mem_endereco,
    output logic [bits-1:0] mem_dado_in,
    input  logic [bits-1:0] mem_dado_out
);

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] LE      = 2'd1;
    localparam logic [1:0] ESCREVE = 2'd2;
    localparam logic [1:0] FIM     = 2'd3;

    logic [1:0]      estado, estado_n;
    logic [bits-1:0] fonte, fonte_n;
    logic [bits-1:0] alvo, alvo_n;
    logic [bits-1:0] restante, restante_n;
    logic [bits-1:0] palavra_n;
    logic            reverso, reverso_n;
    logic            ocupado_n, pronto_n, mem_write_n;
    logic [bits-1:0] mem_endereco_n;
    logic [bits-1:0] diferenca, ultimo;
    logic            reverso_cap;

    // Overlap test decided at capture: copy backwards only when the destination
    // starts inside the source block.
    always_comb begin
        diferenca   = destino - origem;
        ultimo      = quantidade - bits'(1);
        reverso_cap = (destino > origem) && (diferenca < quantidade);
    end

    // Next-state, datapath and next-output computation; outputs are registered
    // from the next state so they line up with the state they describe.
    always_comb begin
        estado_n       = estado;
        fonte_n        = fonte;
        alvo_n         = alvo;
        restante_n     = restante;
        palavra_n      = mem_dado_in;
        reverso_n      = reverso;
        ocupado_n      = 1'b0;
        pronto_n       = 1'b0;
        mem_write_n    = 1'b0;
        mem_endereco_n = '0;

        case (estado)
            OCIOSO: begin
                if (inicio) begin
                    reverso_n  = reverso_cap;
                    restante_n = quantidade;
                    if (reverso_cap) begin
                        fonte_n = origem + ultimo;
                        alvo_n  = destino + ultimo;
                    end else begin
                        fonte_n = origem;
                        alvo_n  = destino;
                    end
                    estado_n = (quantidade == '0) ? FIM : LE;
                end
            end
            LE: begin
                palavra_n = mem_dado_out;
                estado_n  = ESCREVE;
            end
            ESCREVE: begin
                restante_n = restante - bits'(1);
                fonte_n    = reverso ? fonte - bits'(1) : fonte + bits'(1);
                alvo_n     = reverso ? alvo - bits'(1) : alvo + bits'(1);
                estado_n   = (restante == bits'(1)) ? FIM : LE;
            end
            default: begin
                estado_n = OCIOSO;
            end
        endcase

        ocupado_n   = (estado_n != OCIOSO);
        pronto_n    = (estado_n == FIM);
        mem_write_n = (estado_n == ESCREVE);
        if (estado_n == LE) begin
            mem_endereco_n = fonte_n;
        end else if (estado_n == ESCREVE) begin
            mem_endereco_n = alvo_n;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= OCIOSO;
            fonte        <= '0;
            alvo         <= '0;
            restante     <= '0;
            reverso      <= 1'b0;
            mem_dado_in  <= '0;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
            mem_write    <= 1'b0;
            mem_endereco <= '0;
        end else begin
            estado       <= estado_n;
            fonte        <= fonte_n;
            alvo         <= alvo_n;
            restante     <= restante_n;
            reverso      <= reverso_n;
            mem_dado_in  <= palavra_n;
            ocupado      <= ocupado_n;
            pronto       <= pronto_n;
            mem_write    <= mem_write_n;
            mem_endereco <= mem_endereco_n;
        end
    end

endmodule

// File: tb/tb_dma_copia.sv
// tb_dma_copia: directed bench for dma_copia with a behavioural word memory.
module tb_dma_copia;

    logic        clock;
    logic        reset;
    logic        inicio;
    logic [15:0] origem, destino, quantidade;
    logic        ocupado, pronto, mem_write;
    logic [15:0] mem_endereco, mem_dado_in, mem_dado_out;

    logic [15:0] mem [0:65535];
    logic [15:0] wq[$];
    logic [15:0] rq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int pcyc, npr, ecyc;
    bit tmo;

    dma_copia #(.bits(16)) dut (
        .clock(clock),
        .reset(reset),
        .inicio(inicio),
        .origem(origem),
        .destino(destino),
        .quantidade(quantidade),
        .ocupado(ocupado),
        .pronto(pronto),
        .mem_write(mem_write),
        .mem_endereco(mem_endereco),
        .mem_dado_in(mem_dado_in),
        .mem_dado_out(mem_dado_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational read port, write on posedge; log write and read addresses.
    assign mem_dado_out = mem[mem_endereco];
    always @(posedge clock) begin
        if (mem_write) begin
            mem[mem_endereco] <= mem_dado_in;
            wq.push_back(mem_endereco);
        end
        if (ocupado && !mem_write && !pronto) rq.push_back(mem_endereco);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a copy at the current negedge (cycle 0) and steps until idle.
    task automatic run(input logic [15:0] o, input logic [15:0] d, input logic [15:0] q,
                       input int pulse_cyc, input int rst_cyc,
                       output int p_cyc, output int n_pr, output int e_cyc, output bit timeout);
        wq.delete();
        rq.delete();
        origem = o; destino = d; quantidade = q; inicio = 1'b1;
        p_cyc = -1; n_pr = 0; e_cyc = -1; timeout = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            inicio = (c == pulse_cyc);
            reset  = (c == rst_cyc);
            if (pronto) begin
                n_pr++;
                p_cyc = c;
            end
            if (!ocupado) begin
                e_cyc = c;
                timeout = 1'b0;
                break;
            end
        end
        inicio = 1'b0;
        reset  = 1'b0;
        if (timeout) check("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        reset = 1'b1; inicio = 1'b0;
        origem = '0; destino = '0; quantidade = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

        // 1: reset and zero-length copy
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_pronto", 32'(pronto), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_endereco", 32'(mem_endereco), 32'd0);
        check("rst_dado_in", 32'(mem_dado_in), 32'd0);
        run(16'h0010, 16'h0040, 16'd0, -1, -1, pcyc, npr, ecyc, tmo);
        check("q0_pronto_cyc", 32'(pcyc), 32'd1);
        check("q0_pronto_cnt", 32'(npr), 32'd1);
        check("q0_writes", 32'(wq.size()), 32'd0);
        check("q0_end_cyc", 32'(ecyc), 32'd2);

        // 2: plain forward copy of 4 words
        mem[16'h10] = 16'h00A0; mem[16'h11] = 16'h00A1;
        mem[16'h12] = 16'h00A2; mem[16'h13] = 16'h00A3;
        run(16'h0010, 16'h0040, 16'd4, -1, -1, pcyc, npr, ecyc, tmo);
        check("fw_pronto_cyc", 32'(pcyc), 32'd9);
        check("fw_pronto_cnt", 32'(npr), 32'd1);
        check("fw_end_cyc", 32'(ecyc), 32'd10);
        check("fw_writes", 32'(wq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wq.size()) check($sformatf("fw_waddr%0d", i), 32'(wq[i]), 32'h40 + 32'(i));
            check($sformatf("fw_mem%0d", i), 32'(mem[16'h40 + 16'(i)]), 32'hA0 + 32'(i));
        end
        if (rq.size() > 0) check("fw_raddr0", 32'(rq[0]), 32'h10);
        else check("fw_reads", 32'd0, 32'd4);

        // 3: overlapping copy must run backwards
        mem[16'h20] = 16'd1; mem[16'h21] = 16'd2; mem[16'h22] = 16'd3;
        mem[16'h23] = 16'd4; mem[16'h24] = 16'd0; mem[16'h25] = 16'd0;
        run(16'h0020, 16'h0022, 16'd4, -1, -1, pcyc, npr, ecyc, tmo);
        check("ov_writes", 32'(wq.size()), 32'd4);
        if (wq.size() > 0) check("ov_first_waddr", 32'(wq[0]), 32'h25);
        for (int i = 0; i < 4; i++)
            check($sformatf("ov_mem%0d", i), 32'(mem[16'h22 + 16'(i)]), 32'd1 + 32'(i));
        check("ov_src_kept", 32'(mem[16'h21]), 32'd2);

        // 4: source address wraps through 0xFFFF
        mem[16'hFFFE] = 16'h1111; mem[16'hFFFF] = 16'h2222; mem[16'h0000] = 16'h3333;
        run(16'hFFFE, 16'h0100, 16'd3, -1, -1, pcyc, npr, ecyc, tmo);
        check("wr_reads", 32'(rq.size()), 32'd3);
        if (rq.size() == 3) begin
            check("wr_raddr0", 32'(rq[0]), 32'hFFFE);
            check("wr_raddr1", 32'(rq[1]), 32'hFFFF);
            check("wr_raddr2", 32'(rq[2]), 32'h0000);
        end
        check("wr_mem0", 32'(mem[16'h0100]), 32'h1111);
        check("wr_mem1", 32'(mem[16'h0101]), 32'h2222);
        check("wr_mem2", 32'(mem[16'h0102]), 32'h3333);
        check("wr_pronto_cyc", 32'(pcyc), 32'd7);

        // 5: second inicio while busy is ignored
        run(16'h0010, 16'h0050, 16'd4, 3, -1, pcyc, npr, ecyc, tmo);
        check("busy_writes", 32'(wq.size()), 32'd4);
        check("busy_pronto_cnt", 32'(npr), 32'd1);
        check("busy_pronto_cyc", 32'(pcyc), 32'd9);
        repeat (3) @(negedge clock);
        check("busy_stays_idle", 32'(ocupado), 32'd0);
        check("busy_mem3", 32'(mem[16'h53]), 32'hA3);

        // 6: reset in cycle 4 aborts after two writes
        for (int i = 0; i < 4; i++) mem[16'h40 + 16'(i)] = 16'h0000;
        run(16'h0010, 16'h0040, 16'd4, -1, 4, pcyc, npr, ecyc, tmo);
        check("abort_end_cyc", 32'(ecyc), 32'd5);
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_pronto_cnt", 32'(npr), 32'd0);
        check("abort_writes", 32'(wq.size()), 32'd2);
        check("abort_mem0", 32'(mem[16'h40]), 32'hA0);
        check("abort_mem1", 32'(mem[16'h41]), 32'hA1);
        check("abort_mem2", 32'(mem[16'h42]), 32'h0000);

        // 7: destino == origem rewrites in place, forward order
        run(16'h0010, 16'h0010, 16'd2, -1, -1, pcyc, npr, ecyc, tmo);
        check("same_writes", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) check("same_waddr0", 32'(wq[0]), 32'h10);
        check("same_mem1", 32'(mem[16'h11]), 32'hA1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
